// File: rtl/jtgng_main_ctl.sv
// ---------------------------------------------------------------------------
// jtgng_main_ctl
// Main-CPU control registers and handshakes for jtgng-family games.
// The address decoder, the CPU and the RAM are outside this block. This block
// receives decoded chip-select strobes and holds:
//   - the ROM bank register
//   - the flip and sound-reset controls
//   - two saturating coin counters with increment pulses
//   - a small FIFO of sound commands for the sound CPU
//   - the VBLANK interrupt and its acknowledge logic
//   - the soft-reset stretcher that drives the CPU reset
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cen              CPU clock enable; CPU-side state moves only on cen
//   soft_rst         reset requested by the game
//   addr, rnw,       CPU address [2:0], read/not-write, write data
//   cpu_dout
//   bank_cs, ctrl_cs,
//   snd_cs,          decoded selects for each register
//   irqack_cs
//   bs, ba           CPU bus status ({bs,ba}=10 is the interrupt-ack cycle)
//   lvbl             vertical blank, active low
//   snd_pop          sound side takes the head entry (every clk, not gated by cen)
//   nreset           CPU reset, active low
//   bank             ROM bank
//   flip             screen flip
//   sres_b           sound CPU reset, active low
//   coin_cnt1/2      coin counters
//   coin_pulse       one-cen-period pulse for each increment attempt
//   snd_latch        FIFO head (or the last popped value when the FIFO is empty)
//   snd_avail        FIFO not empty
//   snd_ovf          sticky overrun flag
//   nirq             CPU IRQ, active low
// ---------------------------------------------------------------------------
module jtgng_main_ctl #(
  parameter int BANKW       = 3,
  parameter int COINW       = 4,
  parameter int LATCH_DEPTH = 2,
  parameter int IRQ_MODE    = 0,
  parameter int RST_LEN     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             soft_rst,
  input  logic [2:0]       addr,
  input  logic             rnw,
  input  logic [7:0]       cpu_dout,
  input  logic             bank_cs,
  input  logic             ctrl_cs,
  input  logic             snd_cs,
  input  logic             irqack_cs,
  input  logic             bs,
  input  logic             ba,
  input  logic             lvbl,
  input  logic             snd_pop,
  output logic             nreset,
  output logic [BANKW-1:0] bank,
  output logic             flip,
  output logic             sres_b,
  output logic [COINW-1:0] coin_cnt1,
  output logic [COINW-1:0] coin_cnt2,
  output logic [1:0]       coin_pulse,
  output logic [7:0]       snd_latch,
  output logic             snd_avail,
  output logic             snd_ovf,
  output logic             nirq
);

  localparam int AW  = $clog2(LATCH_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = $clog2(RST_LEN + 1);

  // -------------------------------------------------------------------------
  // Soft-reset stretcher. The counter is reloaded while any reset is active.
  // It counts down on cen. The cen that takes it from 1 to 0 releases nreset.
  // -------------------------------------------------------------------------
  logic [RCW-1:0] rst_cnt_reg;
  logic           nreset_reg;

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      rst_cnt_reg <= RCW'(RST_LEN);
      nreset_reg  <= 1'b0;
    end else if (cen && rst_cnt_reg != '0) begin
      rst_cnt_reg <= rst_cnt_reg - RCW'(1);
      if (rst_cnt_reg == RCW'(1))
        nreset_reg <= 1'b1;
    end
  end

  assign nreset = nreset_reg;

  // -------------------------------------------------------------------------
  // Bank and control registers
  // -------------------------------------------------------------------------
  logic             cpu_wr;
  logic [BANKW-1:0] bank_reg;
  logic             flip_reg;
  logic             sres_b_reg;

  assign cpu_wr = cen & ~rnw;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_reg   <= '0;
      flip_reg   <= 1'b0;
      sres_b_reg <= 1'b1;
    end else begin
      if (cpu_wr && bank_cs)
        bank_reg <= cpu_dout[BANKW-1:0];
      if (cpu_wr && ctrl_cs && addr == 3'd0)
        flip_reg <= cpu_dout[0];
      if (cpu_wr && ctrl_cs && addr == 3'd1)
        sres_b_reg <= cpu_dout[0];
    end
  end

  assign bank   = bank_reg;
  assign flip   = flip_reg;
  assign sres_b = sres_b_reg;

  // -------------------------------------------------------------------------
  // Coin counters. Counter gi is at control address 2+gi. An attempt at all
  // ones still produces a pulse, but the count stays at all ones.
  // -------------------------------------------------------------------------
  logic [COINW-1:0] coin_cnt_reg  [2];
  logic [COINW-1:0] coin_cnt_next [2];
  logic [1:0]       coin_inc;
  logic [1:0]       coin_pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_coin
      assign coin_inc[gi] = cpu_wr & ctrl_cs & cpu_dout[0] & (addr == 3'(2 + gi));
      assign coin_cnt_next[gi] = (&coin_cnt_reg[gi]) ? coin_cnt_reg[gi]
                                                     : coin_cnt_reg[gi] + COINW'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        coin_cnt_reg[i] <= '0;
      coin_pulse_reg <= 2'b00;
    end else if (cen) begin
      for (int i = 0; i < 2; i++)
        if (coin_inc[i])
          coin_cnt_reg[i] <= coin_cnt_next[i];
      // Each pulse lasts exactly one cen period.
      coin_pulse_reg <= coin_inc;
    end
  end

  assign coin_cnt1  = coin_cnt_reg[0];
  assign coin_cnt2  = coin_cnt_reg[1];
  assign coin_pulse = coin_pulse_reg;

  // -------------------------------------------------------------------------
  // Sound-command FIFO. The CPU pushes on cen. The sound side pops on any clk.
  // The head must be visible combinationally, so the storage is read without
  // a register.
  // -------------------------------------------------------------------------
  logic [7:0]    fifo_mem [LATCH_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] occ_reg;
  logic [7:0]    last_pop_reg;
  logic          ovf_reg;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign snd_avail = (occ_reg != '0);
  assign full      = (occ_reg == CW'(LATCH_DEPTH));
  assign push      = cpu_wr & snd_cs;
  assign pop       = snd_pop & snd_avail;
  // When the FIFO is full, a pop in the same cycle makes room for the push.
  assign push_ok   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_reg] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      last_pop_reg <= 8'h00;
      ovf_reg      <= 1'b0;
    end else begin
      // The depth is a power of two, so the pointers wrap on their own.
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        last_pop_reg <= fifo_mem[rd_ptr_reg];
      end
      case ({push_ok, pop})
        2'b10:   occ_reg <= occ_reg + CW'(1);
        2'b01:   occ_reg <= occ_reg - CW'(1);
        default: occ_reg <= occ_reg;
      endcase
      if (push && full && !pop)
        ovf_reg <= 1'b1;
    end
  end

  assign snd_latch = snd_avail ? fifo_mem[rd_ptr_reg] : last_pop_reg;
  assign snd_ovf   = ovf_reg;

  // -------------------------------------------------------------------------
  // VBLANK interrupt. A falling edge of lvbl, seen on cen, sets the IRQ.
  // If a set and a clear happen on the same cen, the set wins.
  // -------------------------------------------------------------------------
  logic last_lvbl_reg;
  logic nirq_reg;
  logic irq_set;
  logic irq_clr;

  assign irq_set = last_lvbl_reg & ~lvbl;

  generate
    if (IRQ_MODE == 0) begin : g_ack_bus
      assign irq_clr = bs & ~ba;
    end else begin : g_ack_reg
      assign irq_clr = irqack_cs & ~rnw;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lvbl_reg <= 1'b1;
      nirq_reg      <= 1'b1;
    end else if (cen) begin
      last_lvbl_reg <= lvbl;
      if (irq_set)
        nirq_reg <= 1'b0;
      else if (irq_clr)
        nirq_reg <= 1'b1;
    end
  end

  assign nirq = nirq_reg;

endmodule

// File: tb/tb_jtgng_main_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for jtgng_main_ctl.
// Two instances share every input. dut0 acknowledges the IRQ on the bus-ack
// cycle, and dut1 acknowledges it on a write to the ack register.
// The bench runs directed sequences, a table of register accesses, and then
// a random phase. In the random phase a behavioural model checks every output.
// ---------------------------------------------------------------------------
module tb_jtgng_main_ctl;

  localparam int BANKW = 3;
  localparam int COINW = 4;
  localparam int DEPTH = 2;
  localparam int RLEN  = 8;

  logic clk = 1'b0;
  logic rst, cen, soft_rst, rnw, bank_cs, ctrl_cs, snd_cs, irqack_cs;
  logic bs, ba, lvbl, snd_pop;
  logic [2:0] addr;
  logic [7:0] cpu_dout;

  logic             nreset0, nreset1, flip0, flip1, sres0, sres1;
  logic             avail0, avail1, ovf0, ovf1, nirq0, nirq1;
  logic [BANKW-1:0] bank0, bank1;
  logic [COINW-1:0] c1_0, c2_0, c1_1, c2_1;
  logic [1:0]       pulse0, pulse1;
  logic [7:0]       latch0, latch1;

  always #5 clk = ~clk;

  jtgng_main_ctl #(.BANKW(BANKW), .COINW(COINW), .LATCH_DEPTH(DEPTH),
                   .IRQ_MODE(0), .RST_LEN(RLEN)) dut0 (
    .clk(clk), .rst(rst), .cen(cen), .soft_rst(soft_rst), .addr(addr),
    .rnw(rnw), .cpu_dout(cpu_dout), .bank_cs(bank_cs), .ctrl_cs(ctrl_cs),
    .snd_cs(snd_cs), .irqack_cs(irqack_cs), .bs(bs), .ba(ba), .lvbl(lvbl),
    .snd_pop(snd_pop), .nreset(nreset0), .bank(bank0), .flip(flip0),
    .sres_b(sres0), .coin_cnt1(c1_0), .coin_cnt2(c2_0), .coin_pulse(pulse0),
    .snd_latch(latch0), .snd_avail(avail0), .snd_ovf(ovf0), .nirq(nirq0));

  jtgng_main_ctl #(.BANKW(BANKW), .COINW(COINW), .LATCH_DEPTH(DEPTH),
                   .IRQ_MODE(1), .RST_LEN(RLEN)) dut1 (
    .clk(clk), .rst(rst), .cen(cen), .soft_rst(soft_rst), .addr(addr),
    .rnw(rnw), .cpu_dout(cpu_dout), .bank_cs(bank_cs), .ctrl_cs(ctrl_cs),
    .snd_cs(snd_cs), .irqack_cs(irqack_cs), .bs(bs), .ba(ba), .lvbl(lvbl),
    .snd_pop(snd_pop), .nreset(nreset1), .bank(bank1), .flip(flip1),
    .sres_b(sres1), .coin_cnt1(c1_1), .coin_cnt2(c2_1), .coin_pulse(pulse1),
    .snd_latch(latch1), .snd_avail(avail1), .snd_ovf(ovf1), .nirq(nirq1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bank_cs = 0; ctrl_cs = 0; snd_cs = 0; irqack_cs = 0;
    rnw = 1; addr = 0; cpu_dout = 0; snd_pop = 0; bs = 0; ba = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // sel: 0 = bank, 1 = ctrl, 2 = snd, 3 = irqack
  task automatic cpu_acc(input int sel, input logic [2:0] a, input logic [7:0] d,
                         input logic r);
    bank_cs = (sel == 0); ctrl_cs = (sel == 1);
    snd_cs = (sel == 2); irqack_cs = (sel == 3);
    addr = a; cpu_dout = d; rnw = r; cen = 1;
    tick();
    idle_inputs();
  endtask

  task automatic pop_once();
    snd_pop = 1; cen = 0; tick(); snd_pop = 0; cen = 1;
  endtask

  // Table of bank and control accesses with the register state expected after each one.
  typedef struct {
    int         sel;
    logic [2:0] a;
    logic [7:0] d;
    logic       r;
    logic [2:0] e_bank;
    logic       e_flip;
    logic       e_sres;
  } vec_t;
  vec_t vecs[9];

  // ---------------- behavioural reference model ----------------
  int         m_since;
  logic       m_nreset, m_flip, m_sres, m_ovf, m_lastlvbl, m_nirq0, m_nirq1;
  logic [2:0] m_bank;
  int         m_c1, m_c2;
  logic [1:0] m_pulse;
  logic [7:0] m_q[$];
  logic [7:0] m_last;

  task automatic model_reset();
    m_since = 0; m_nreset = 0; m_bank = 0; m_flip = 0; m_sres = 1;
    m_c1 = 0; m_c2 = 0; m_pulse = 0; m_q.delete(); m_last = 0; m_ovf = 0;
    m_lastlvbl = 1; m_nirq0 = 1; m_nirq1 = 1;
  endtask

  // Advance the model by one clk, using the inputs as they are now.
  task automatic model_step();
    bit wr, pop_ok, full_old, push, inc1, inc2, fall;
    if (rst) begin
      model_reset();
      return;
    end
    // The CPU reset is released once RST_LEN cens have passed since the last reset request.
    if (soft_rst) begin
      m_since = 0; m_nreset = 0;
    end else if (cen) begin
      m_since++;
      if (m_since >= RLEN) m_nreset = 1;
    end
    wr = cen && !rnw;
    full_old = (m_q.size() == DEPTH);
    pop_ok = snd_pop && (m_q.size() > 0);
    push = wr && snd_cs;
    if (pop_ok) m_last = m_q.pop_front();
    if (push) begin
      if (full_old && !pop_ok) m_ovf = 1;
      else m_q.push_back(cpu_dout);
    end
    if (cen) begin
      if (wr && bank_cs) m_bank = cpu_dout[2:0];
      if (wr && ctrl_cs && addr == 0) m_flip = cpu_dout[0];
      if (wr && ctrl_cs && addr == 1) m_sres = cpu_dout[0];
      inc1 = wr && ctrl_cs && addr == 2 && cpu_dout[0];
      inc2 = wr && ctrl_cs && addr == 3 && cpu_dout[0];
      if (inc1) m_c1 = (m_c1 + 1 > 15) ? 15 : m_c1 + 1;
      if (inc2) m_c2 = (m_c2 + 1 > 15) ? 15 : m_c2 + 1;
      m_pulse = {inc2, inc1};
      fall = m_lastlvbl && !lvbl;
      if (fall) m_nirq0 = 0; else if (bs && !ba) m_nirq0 = 1;
      if (fall) m_nirq1 = 0; else if (irqack_cs && !rnw) m_nirq1 = 1;
      m_lastlvbl = lvbl;
    end
  endtask

  task automatic model_compare();
    chk("r_nreset", nreset0, m_nreset);
    chk("r_bank", bank0, m_bank);
    chk("r_flip", flip0, m_flip);
    chk("r_sres", sres0, m_sres);
    chk("r_coin1", c1_0, m_c1);
    chk("r_coin2", c2_0, m_c2);
    chk("r_pulse", pulse0, m_pulse);
    chk("r_avail", avail0, m_q.size() > 0);
    chk("r_latch", latch0, (m_q.size() > 0) ? m_q[0] : m_last);
    chk("r_ovf", ovf0, m_ovf);
    chk("r_nirq0", nirq0, m_nirq0);
    chk("r_nirq1", nirq1, m_nirq1);
  endtask

  initial begin
    int pulses;
    idle_inputs();
    rst = 1; cen = 1; soft_rst = 0; lvbl = 1;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_nreset", nreset0, 0);
    chk("rst_bank", bank0, 0);
    chk("rst_flip", flip0, 0);
    chk("rst_sres", sres0, 1);
    chk("rst_coins", {c1_0, c2_0}, 0);
    chk("rst_pulse", pulse0, 0);
    chk("rst_latch", latch0, 0);
    chk("rst_avail", avail0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_nirq", {nirq0, nirq1}, 2'b11);
    rst = 0;

    // ---------------- soft reset stretch ----------------
    soft_rst = 1; cen = 1;
    repeat (3) tick();
    chk("soft_hold", nreset0, 0);
    soft_rst = 0;
    for (int k = 1; k <= RLEN; k++) begin
      cen = 0; tick();
      chk("soft_nocen", nreset0, 0);
      cen = 1; tick();
      chk("soft_count", nreset0, (k == RLEN));
    end
    soft_rst = 1; tick(); soft_rst = 0;
    repeat (4) tick();
    chk("soft_mid", nreset0, 0);
    soft_rst = 1; tick(); soft_rst = 0;
    for (int k = 1; k <= RLEN; k++) begin
      tick();
      chk("soft_restart", nreset0, (k == RLEN));
    end

    // ---------------- table-driven register accesses ----------------
    vecs[0] = '{0, 3'd0, 8'h06, 1'b0, 3'd6, 1'b0, 1'b1};
    vecs[1] = '{1, 3'd0, 8'h01, 1'b0, 3'd6, 1'b1, 1'b1};
    vecs[2] = '{1, 3'd1, 8'h00, 1'b0, 3'd6, 1'b1, 1'b0};
    vecs[3] = '{1, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 1'b0};
    vecs[4] = '{0, 3'd0, 8'h03, 1'b1, 3'd6, 1'b1, 1'b0};
    vecs[5] = '{1, 3'd4, 8'h00, 1'b0, 3'd6, 1'b1, 1'b0};
    vecs[6] = '{1, 3'd0, 8'hFE, 1'b0, 3'd6, 1'b0, 1'b0};
    vecs[7] = '{0, 3'd0, 8'hFD, 1'b0, 3'd5, 1'b0, 1'b0};
    vecs[8] = '{1, 3'd1, 8'h01, 1'b0, 3'd5, 1'b0, 1'b1};
    foreach (vecs[i]) begin
      cpu_acc(vecs[i].sel, vecs[i].a, vecs[i].d, vecs[i].r);
      $display("[TB] vec %0d sel=%0d a=%0d d=%02h rnw=%0b -> bank=%0d flip=%0b sres_b=%0b",
               i, vecs[i].sel, vecs[i].a, vecs[i].d, vecs[i].r, bank0, flip0, sres0);
      chk("vec_bank", bank0, vecs[i].e_bank);
      chk("vec_flip", flip0, vecs[i].e_flip);
      chk("vec_sres", sres0, vecs[i].e_sres);
    end

    // ---------------- coin saturation ----------------
    pulses = 0;
    for (int k = 0; k < 17; k++) begin
      cpu_acc(1, 3'd2, 8'h01, 1'b0);
      if (pulse0[0]) pulses++;
    end
    chk("coin1_sat", c1_0, 15);
    chk("coin1_pulses", pulses, 17);
    tick();
    chk("coin_pulse_end", pulse0, 0);
    repeat (3) cpu_acc(1, 3'd3, 8'h00, 1'b0);
    chk("coin2_zero", c2_0, 0);
    chk("coin2_nopulse", pulse0[1], 0);

    // ---------------- sound FIFO ----------------
    do_reset();
    cpu_acc(2, 3'd0, 8'h11, 1'b0);
    cpu_acc(2, 3'd0, 8'h22, 1'b0);
    cpu_acc(2, 3'd0, 8'h33, 1'b0);
    chk("fifo_ovf", ovf0, 1);
    chk("fifo_head", latch0, 8'h11);
    pop_once();
    chk("fifo_pop1", latch0, 8'h22);
    pop_once();
    chk("fifo_empty", avail0, 0);
    chk("fifo_last", latch0, 8'h22);
    pop_once();
    chk("fifo_pop_empty", latch0, 8'h22);
    chk("fifo_ovf_sticky", ovf0, 1);
    do_reset();
    cpu_acc(2, 3'd0, 8'hA1, 1'b0);
    cpu_acc(2, 3'd0, 8'hB2, 1'b0);
    snd_pop = 1;
    cpu_acc(2, 3'd0, 8'hC3, 1'b0);
    chk("fifo_pp_noovf", ovf0, 0);
    chk("fifo_pp_head", latch0, 8'hB2);
    pop_once();
    chk("fifo_pp_next", latch0, 8'hC3);
    pop_once();
    chk("fifo_pp_empty", {avail0, latch0}, {1'b0, 8'hC3});

    // ---------------- IRQ ----------------
    lvbl = 1; tick();
    lvbl = 0; tick();
    chk("irq_set", {nirq0, nirq1}, 2'b00);
    bs = 1; ba = 0; tick(); bs = 0;
    chk("irq_bus_ack", {nirq0, nirq1}, 2'b10);
    cpu_acc(3, 3'd0, 8'h00, 1'b0);
    chk("irq_reg_ack", {nirq0, nirq1}, 2'b11);
    lvbl = 1; tick();
    lvbl = 0; bs = 1; ba = 0; irqack_cs = 1; rnw = 0;
    tick();
    idle_inputs();
    chk("irq_set_wins", {nirq0, nirq1}, 2'b00);
    cpu_acc(2, 3'd0, 8'h5A, 1'b0);
    chk("irq_fifo_half", avail0, 1);
    do_reset();
    chk("irq_rst_nirq", {nirq0, nirq1}, 2'b11);
    chk("irq_rst_fifo", {avail0, latch0}, 0);

    // ---------------- random phase against the model ----------------
    do_reset();
    lvbl = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      soft_rst  = ($urandom_range(0, 79) == 0);
      cen       = $urandom_range(0, 1);
      addr      = 3'($urandom_range(0, 7));
      rnw       = $urandom_range(0, 1);
      cpu_dout  = 8'($urandom);
      bank_cs   = ($urandom_range(0, 3) == 0);
      ctrl_cs   = ($urandom_range(0, 2) == 0);
      snd_cs    = ($urandom_range(0, 2) == 0);
      irqack_cs = ($urandom_range(0, 5) == 0);
      bs        = $urandom_range(0, 1);
      ba        = $urandom_range(0, 1);
      snd_pop   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) lvbl = ~lvbl;
      model_step();
      tick();
      model_compare();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtgng_main_ctl.md
Name: jtgng_main_ctl

Overview:
Parametrised control-register and handshake block for the main CPU. It sits between the address decoder and the CPU core in every jtgng-family game. It holds the ROM bank register, the flip and sound-reset controls, saturating coin counters, a multi-entry sound-command FIFO toward the sound CPU, the VBLANK interrupt generator with selectable acknowledge mode, and the soft-reset stretcher. CPU, RAM and decoder remain external; this block receives decoded strobes.

Parameters:
BANKW, 3, width of ROM bank register
COINW, 4, width of each coin counter (saturating)
LATCH_DEPTH, 2, sound FIFO entries (power of 2, >=2)
IRQ_MODE, 0, 0 = clear on CPU interrupt-ack cycle ({bs,ba}=10); 1 = clear on write to irqack_cs
RST_LEN, 8, cen cycles nreset stays low after soft_rst falls

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  CPU clock enable; all CPU-side state advances only on cen
soft_rst  in  1  game-requested reset
addr  in  3  CPU address bits [2:0]
rnw  in  1  CPU read/not-write
cpu_dout  in  8  CPU write data
bank_cs  in  1  bank register select
ctrl_cs  in  1  control region select (flip/sres/coins)
snd_cs  in  1  sound command select
irqack_cs  in  1  IRQ acknowledge register select
bs, ba  in  1 each  CPU bus status
lvbl  in  1  vertical blank, active low
snd_pop  in  1  sound side consumes head entry (clk domain, no cen)
nreset  out  1  CPU reset, active low
bank  out  BANKW  ROM bank
flip  out  1  screen flip
sres_b  out  1  sound CPU reset, active low
coin_cnt1, coin_cnt2  out  COINW  coin counters
coin_pulse  out  2  one-cen-cycle pulse per counter increment
snd_latch  out  8  FIFO head
snd_avail  out  1  FIFO not empty
snd_ovf  out  1  sticky overrun flag
nirq  out  1  CPU IRQ, active low

Behaviour:
- Reset values:
  - nreset=0, bank=0, flip=0, sres_b=1
  - coin_cnt1 = coin_cnt2 = 0, coin_pulse=0
  - snd_latch=0, snd_avail=0, snd_ovf=0
  - nirq=1
  - FIFO pointers=0, last_lvbl=1
- nreset:
  - Low while rst or soft_rst.
  - After soft_rst falls, stays low for exactly RST_LEN cen pulses, then goes high on the cen edge.
  - Re-asserting soft_rst mid-count restarts the count.
- bank: on cen with bank_cs & !rnw, bank <= cpu_dout[BANKW-1:0]. Reads have no effect.
- Control writes: on cen with ctrl_cs & !rnw, decoded by addr:
  - 0: flip <= cpu_dout[0]
  - 1: sres_b <= cpu_dout[0]
  - 2: coin_cnt1 increments if cpu_dout[0]
  - 3: coin_cnt2 increments if cpu_dout[0]
  - 4-7: ignored
  - Reads in this region change nothing.
- Coin counters:
  - Saturate at all ones; no wrap.
  - coin_pulse[n] is high for one cen period on each increment, including a saturated attempt.
- Sound FIFO:
  - Push on cen with snd_cs & !rnw.
  - Pop on any clk with snd_pop & snd_avail; snd_pop while empty is ignored.
  - snd_latch shows the head entry combinationally from storage, or the last popped value when empty.
  - Push while full and no simultaneous pop: data dropped, snd_ovf <= 1 (sticky until rst).
  - Simultaneous push and pop while full: both take effect, no overrun.
  - Occupancy counter is log2(LATCH_DEPTH)+1 bits wide.
- IRQ:
  - last_lvbl samples lvbl on cen.
  - last_lvbl=1 & lvbl=0 sets nirq <= 0.
  - Clear in IRQ_MODE 0: on cen with {bs,ba}=2'b10.
  - Clear in IRQ_MODE 1: on cen with irqack_cs & !rnw.
  - Set and clear in the same cen: set wins (nirq=0).
- Synchronous rst overrides everything in any state, including a half-full FIFO or a pending IRQ.

Test Plan:
- Soft reset with RST_LEN=8: assert soft_rst 3 cen, release → nreset stays 0 for 8 cen pulses, then 1; re-assert after 4 → count restarts.
- Bank and control writes with BANKW=3: write 0x06 to bank_cs → bank=6. Write 1 at addr 0 → flip=1. Write 0 at addr 1 → sres_b=0. Read at addr 0 → flip unchanged.
- Coin saturation with COINW=4: 17 writes of 1 at addr 2 → coin_cnt1=15, 17 coin_pulse[0] pulses; addr 3 writes of 0 → coin_cnt2=0.
- Sound FIFO, LATCH_DEPTH=2:
  - Push 0x11, 0x22, 0x33 → snd_ovf=1, snd_latch=0x11.
  - Pop → 0x22; pop → snd_avail=0, snd_latch=0x22.
  - Separately, push+pop while full → no overrun.
- IRQ MODE 0: lvbl 1→0 → nirq=0 next cen; {bs,ba}=10 → nirq=1; ack coinciding with a new falling edge → nirq stays 0.
- IRQ MODE 1: {bs,ba}=10 leaves nirq=0; write to irqack_cs → nirq=1; rst mid-frame → nirq=1, FIFO empty.
